sa_skew_feeder: RTL
===================

// Module: sa_skew_feeder
// PURPOSE
//  Downstream consumer of the per-row input buffers. Issues read pulses to ROWS buffers
//  on a diagonal (wavefront) schedule: row r starts r cycles after row 0. Registers the
//  words read into a zero-padded, skewed west-edge data bus for the systolic array.
//  One start runs one tile of KDIM words per row. Supports a downstream stall.
// PARAMETERS
//  WORDLEN  8   data word width (matches the input buffers)
//  ROWS     4   array rows = buffers driven
//  KDIM     16  words per row per tile (>=1)
//  CNTW     5   step counter width; must satisfy 2^CNTW > KDIM+ROWS-1
// PORTS
//  clk        in   1             single clock, all logic on posedge
//  rstn       in   1             synchronous, active-low reset
//  start      in   1             begin tile; sampled in IDLE only
//  stall      in   1             downstream hold; freezes schedule and outputs
//  busy       out  1             high in FEED, FLUSH and DONE
//  done       out  1             one-cycle pulse in DONE
//  buf_read   out  ROWS          read strobe per buffer (combinational from state/step)
//  buf_dout   in   ROWS*WORDLEN  buffer outputs; row r = [r*WORDLEN +: WORDLEN]
//  arr_data   out  ROWS*WORDLEN  skewed data to array west edge; 0 when not valid
//  arr_valid  out  ROWS          per-row valid, aligned with arr_data
// BEHAVIOUR
//  - Reset (rstn=0 at posedge): state=IDLE, step=0, pend=0, arr_data=0, arr_valid=0,
//    busy=0, done=0, buf_read=0. Reset mid-tile aborts; no further reads are issued.
//  - Buffers have 1-cycle registered read: buf_dout row r is valid from the cycle after
//    buf_read[r], and holds until the next read of that row.
//  - FSM: IDLE -start-> FEED (step=0). FEED: step++ on each non-stall cycle. At step=KDIM+ROWS-2
//    with !stall -> FLUSH. FLUSH: one non-stall cycle -> DONE. DONE: one cycle -> IDLE,
//    regardless of stall. start outside IDLE is ignored.
//  - Read: buf_read[r] = (state==FEED) & !stall & (r <= step <= r+KDIM-1). Exactly KDIM
//    reads per row per tile; no reads in IDLE/FLUSH/DONE.
//  - Per-row pend[r]: set at edge after a read; on every non-stall cycle:
//    arr_valid[r] <= pend[r]; arr_data[r] <= pend[r] ? buf_dout[r] : 0; pend[r] cleared
//    unless a new read of r issues in the same cycle (then it stays set).
//  - Stall cycle: no reads, step/state frozen (except DONE), arr_data/arr_valid/pend hold.
//    Pending word stays in the buffer output register and is captured on first non-stall cycle.
//  - Latency: read in cycle t -> word on arr_data in cycle t+2 (no stall).
//  - Cycle 0 = first FEED cycle: row r valid cycles r+2..r+KDIM+1. done is in cycle
//    KDIM+ROWS, same cycle as last row's final word. arr_valid=0 the cycle after (no stall).
//  - No empty check on buffers; the loader guarantees KDIM words per row before start.
// STRUCTURE
//  - Shared package sa_pkg: WORDLEN default, FSM state encoding (IDLE/FEED/FLUSH/DONE).
//  - One sub-module sa_skew_lane (generate x ROWS): per-row window compare, pend flag,
//    arr_data/arr_valid registers; top holds FSM and step counter.
// TESTING
//  1 Nominal ROWS=4,KDIM=3, buffer r holds 10r+1..10r+3; start -> row0 valid cycles 2-4
//    (1,2,3), row3 cycles 5-7 (31,32,33), done cycle 7, zeros elsewhere.
//  2 stall high cycles 3-4 of test 1 -> buf_read and arr_* frozen 2 cycles; same per-row
//    sequences, every event after cycle 2 shifted +2, done cycle 9; no word lost or duplicated.
//  3 start held high through the tile and pulsed during DONE -> exactly one tile (12 reads);
//    IDLE start the cycle after DONE begins a second tile cleanly.
//  4 rstn low in cycle 4 of test 1 -> next cycle all outputs 0, state IDLE, no reads.
//  5 KDIM=1,ROWS=1 -> buf_read in cycle 0 only, arr_valid cycle 2, done cycle 2.
//  6 stall during DONE -> done still a single cycle; arr_data/arr_valid hold until stall drops.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array skew feeder: default word width
// and the tile-sequencer state encoding.
package sa_pkg;

    localparam int WORDLEN_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } sa_state_e;

endpackage

// File: rtl/sa_skew_lane.sv
// One west-edge lane: decides when its row buffer is read in the wavefront,
// tracks the outstanding word and registers it onto the array edge.
module sa_skew_lane
    import sa_pkg::*;
#(
    parameter int WORDLEN = WORDLEN_DEF,
    parameter int KDIM    = 16,
    parameter int CNTW    = 5,
    parameter int ROW     = 0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               feed,
    input  logic               stall,
    input  logic [CNTW-1:0]    step,
    input  logic [WORDLEN-1:0] buf_dout,
    output logic               buf_read,
    output logic [WORDLEN-1:0] arr_data,
    output logic               arr_valid
);

    localparam logic [CNTW-1:0] ROW_OFS  = CNTW'(ROW);
    localparam logic [CNTW-1:0] WIN_LAST = CNTW'(KDIM - 1);

    logic [CNTW-1:0]    rel_step;
    logic               pend_d, pend_q;
    logic               arr_valid_d, arr_valid_q;
    logic [WORDLEN-1:0] arr_data_d, arr_data_q;

    // step - ROW wraps to a value above KDIM-1 whenever step < ROW, because the
    // counter is wide enough to hold KDIM+ROWS-1; one compare covers both bounds.
    always_comb begin
        rel_step    = step - ROW_OFS;
        buf_read    = feed && !stall && (rel_step <= WIN_LAST);
        pend_d      = pend_q;
        arr_valid_d = arr_valid_q;
        arr_data_d  = arr_data_q;
        if (!stall) begin
            arr_valid_d = pend_q;
            arr_data_d  = pend_q ? buf_dout : '0;
            pend_d      = buf_read;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pend_q      <= 1'b0;
            arr_valid_q <= 1'b0;
            arr_data_q  <= '0;
        end else begin
            pend_q      <= pend_d;
            arr_valid_q <= arr_valid_d;
            arr_data_q  <= arr_data_d;
        end
    end

    assign arr_valid = arr_valid_q;
    assign arr_data  = arr_data_q;

endmodule

// File: rtl/sa_skew_feeder.sv
// Tile sequencer feeding a systolic array from per-row buffers on a diagonal
// schedule; row r starts r cycles after row 0 and the stream honours a stall.
module sa_skew_feeder
    import sa_pkg::*;
#(
    parameter int WORDLEN = WORDLEN_DEF,
    parameter int ROWS    = 4,
    parameter int KDIM    = 16,
    parameter int CNTW    = 5
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic                    stall,
    output logic                    busy,
    output logic                    done,
    output logic [ROWS-1:0]         buf_read,
    input  logic [ROWS*WORDLEN-1:0] buf_dout,
    output logic [ROWS*WORDLEN-1:0] arr_data,
    output logic [ROWS-1:0]         arr_valid
);

    // Last step at which the bottom row still issues its final read.
    localparam logic [CNTW-1:0] LAST_STEP = CNTW'(KDIM + ROWS - 2);

    sa_state_e       state_d, state_q;
    logic [CNTW-1:0] step_d, step_q;
    logic            feed;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            ST_IDLE: begin
                step_d = '0;
                if (start) begin
                    state_d = ST_FEED;
                end
            end
            ST_FEED: begin
                if (!stall) begin
                    if (step_q == LAST_STEP) begin
                        state_d = ST_FLUSH;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (!stall) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    assign feed = (state_q == ST_FEED);
    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        sa_skew_lane #(
            .WORDLEN (WORDLEN),
            .KDIM    (KDIM),
            .CNTW    (CNTW),
            .ROW     (r)
        ) u_lane (
            .clk       (clk),
            .rstn      (rstn),
            .feed      (feed),
            .stall     (stall),
            .step      (step_q),
            .buf_dout  (buf_dout[r*WORDLEN +: WORDLEN]),
            .buf_read  (buf_read[r]),
            .arr_data  (arr_data[r*WORDLEN +: WORDLEN]),
            .arr_valid (arr_valid[r])
        );
    end

endmodule
